// File: rtl/intr_ctrl.sv
// Programmable interrupt controller: latches and masks N_IRQ device requests, picks the
// lowest-index eligible source and runs the intr/inta/EOI handshake with the CPU.
module intr_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter logic [31:0] RESET_MODE = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq,
    input  logic             inta,
    output logic             intr,
    output logic [4:0]       int_id,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] mode_q, mode_d;
    logic [4:0]       int_id_q, int_id_d;
    logic [4:0]       cur_id_q, cur_id_d;

    logic [N_IRQ-1:0] pend_vis;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] clr;
    logic [4:0]       winner;
    logic             wr;

    // pend_q only holds edge-mode bits; level-mode bits mirror the sampled input.
    assign pend_vis = (pend_q & mode_q) | (irq_q & ~mode_q);
    assign eligible = pend_vis & mask_q;
    assign wr       = sel & we;

    always_comb begin
        winner = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 5'(i);
            end
        end
    end

    always_comb begin
        irq_d    = irq;
        mask_d   = mask_q;
        mode_d   = mode_q;
        state_d  = state_q;
        int_id_d = int_id_q;
        cur_id_d = cur_id_q;
        clr      = '0;

        if (wr) begin
            unique case (addr)
                2'd0:    clr    = wdata[N_IRQ-1:0];
                2'd1:    mask_d = wdata[N_IRQ-1:0];
                2'd2:    mode_d = wdata[N_IRQ-1:0];
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d  = StReq;
                    int_id_d = winner;
                end
            end
            StReq: begin
                int_id_d = winner;
                if (inta) begin
                    state_d  = StService;
                    cur_id_d = int_id_q;
                    clr      = clr | (N_IRQ'(1) << int_id_q);
                end else if (!(|eligible)) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (wr && addr == 2'd3) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new edge wins over a same-cycle clear; level bits are held at zero so a
        // switch to edge mode starts from a clean slate.
        pend_d = ((pend_q & ~clr) | (irq & ~irq_q)) & mode_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            mode_q   <= RESET_MODE[N_IRQ-1:0];
            int_id_q <= '0;
            cur_id_q <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            int_id_q <= int_id_d;
            cur_id_q <= cur_id_d;
        end
    end

    assign intr   = (state_q == StReq);
    assign int_id = int_id_q;

    always_comb begin
        rdata = '0;
        unique case (addr)
            2'd0: rdata[N_IRQ-1:0] = pend_vis;
            2'd1: rdata[N_IRQ-1:0] = mask_q;
            2'd2: rdata[N_IRQ-1:0] = mode_q;
            2'd3: begin
                rdata[9:8] = state_q;
                rdata[4:0] = cur_id_q;
            end
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expectations are queued as each step is driven and popped
// when the DUT output or register is sampled.
module tb_intr_ctrl;

    localparam int unsigned NIrq = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NIrq-1:0] irq;
    logic            inta;
    logic            intr;
    logic [4:0]      int_id;
    logic            sel;
    logic            we;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    intr_ctrl #(
        .N_IRQ      (NIrq),
        .RESET_MODE (32'h0000_00A5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq    (irq),
        .inta   (inta),
        .intr   (intr),
        .int_id (int_id),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=0x%0h", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
        expect_val(tag, e);
        addr = a;
        #1;
        compare(rdata);
    endtask

    task automatic chk_intr(input string tag, input logic e);
        expect_val(tag, {31'b0, e});
        compare({31'b0, intr});
    endtask

    task automatic chk_id(input string tag, input logic [4:0] e);
        expect_val(tag, {27'b0, e});
        compare({27'b0, int_id});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        sel   = 1'b0;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        irq   = '0;
        inta  = 1'b0;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk_intr("rst_intr", 1'b0);
        chk_id("rst_id", 5'd0);
        chk_reg("rst_pend", 2'd0, 32'h0);
        chk_reg("rst_mask", 2'd1, 32'h0);
        chk_reg("rst_mode", 2'd2, 32'hA5);
        chk_reg("rst_stat", 2'd3, 32'h0);

        // 1: single edge source through the full handshake
        wr(2'd1, 32'h01);
        wr(2'd2, 32'h01);
        irq = 8'h01;
        tick();
        irq = '0;
        chk_reg("t1_pend", 2'd0, 32'h01);
        chk_intr("t1_intr_lat1", 1'b0);
        tick();
        chk_intr("t1_intr", 1'b1);
        chk_id("t1_id", 5'd0);
        ack();
        chk_intr("t1_intr_after_ack", 1'b0);
        chk_reg("t1_pend_after_ack", 2'd0, 32'h0);
        chk_reg("t1_stat_service", 2'd3, 32'h200);
        wr(2'd3, 32'h0);
        chk_reg("t1_stat_eoi", 2'd3, 32'h000);

        // 2: two simultaneous edges, priority then re-request after EOI
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'hFF);
        irq = 8'h24;
        tick();
        irq = '0;
        tick();
        chk_intr("t2_intr", 1'b1);
        chk_id("t2_id_first", 5'd2);
        chk_reg("t2_pend", 2'd0, 32'h24);
        ack();
        chk_reg("t2_stat", 2'd3, 32'h202);
        chk_reg("t2_pend_after_ack", 2'd0, 32'h20);
        wr(2'd3, 32'h0);
        chk_intr("t2_intr_eoi_cycle", 1'b0);
        tick();
        chk_intr("t2_intr_rerise", 1'b1);
        chk_id("t2_id_second", 5'd5);
        ack();
        wr(2'd3, 32'h0);

        // 3: level source held high, re-request, then dropped while requesting
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h08);
        irq = 8'h08;
        tick();
        tick();
        chk_intr("t3_intr", 1'b1);
        chk_id("t3_id", 5'd3);
        ack();
        chk_intr("t3_intr_after_ack", 1'b0);
        chk_reg("t3_stat", 2'd3, 32'h203);
        wr(2'd3, 32'h0);
        tick();
        chk_intr("t3_rereq", 1'b1);
        irq = '0;
        tick();
        tick();
        chk_intr("t3_intr_drop", 1'b0);
        chk_reg("t3_stat_idle", 2'd3, 32'h003);

        // 4: pending while masked, then unmasked
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h00);
        irq = 8'h02;
        tick();
        irq = '0;
        chk_reg("t4_pend", 2'd0, 32'h02);
        tick();
        chk_intr("t4_masked", 1'b0);
        wr(2'd1, 32'h02);
        chk_intr("t4_mask_lat", 1'b0);
        tick();
        chk_intr("t4_intr", 1'b1);
        chk_id("t4_id", 5'd1);
        ack();
        wr(2'd3, 32'h0);

        // 5a: W1C racing a new edge on the same bit, then a plain W1C
        wr(2'd1, 32'h00);
        irq = 8'h10;
        tick();
        irq = '0;
        tick();
        chk_reg("t5_pend_pre", 2'd0, 32'h10);
        irq = 8'h10;
        wr(2'd0, 32'h10);
        chk_reg("t5_set_beats_clr", 2'd0, 32'h10);
        irq = '0;
        wr(2'd0, 32'h10);
        chk_reg("t5_w1c", 2'd0, 32'h00);

        // 5b: EOI and inta while idle
        wr(2'd3, 32'h0);
        chk_reg("t5_eoi_idle", 2'd3, 32'h001);
        ack();
        chk_reg("t5_inta_idle", 2'd3, 32'h001);
        chk_intr("t5_intr_idle", 1'b0);

        // 6: reset while requesting
        wr(2'd1, 32'h01);
        wr(2'd2, 32'h01);
        irq = 8'h01;
        tick();
        irq = '0;
        tick();
        chk_intr("t6_intr_pre", 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_intr("t6_intr", 1'b0);
        chk_id("t6_id", 5'd0);
        chk_reg("t6_pend", 2'd0, 32'h0);
        chk_reg("t6_mask", 2'd1, 32'h0);
        chk_reg("t6_mode", 2'd2, 32'hA5);
        chk_reg("t6_stat", 2'd3, 32'h0);
        tick();
        chk_intr("t6_intr_hold", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
